// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file write/read port arbiter.
package regfile_arb_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int unsigned WRITE_RSP_DATA = 0;

endpackage

// File: rtl/regfile_arb_starve_cnt.sv
// Saturating count of cycles a pending debug write has lost the write port.
module regfile_arb_starve_cnt #(
    parameter int LIMIT = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         inc,
    output logic [$clog2(LIMIT+1)-1:0]   cnt
);

    localparam int W = $clog2(LIMIT + 1);

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (v == W'(LIMIT)) ? v : v + W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= sat_inc(cnt);
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Arbitrates the register-file write port and debug read port between core
// writeback and a debug requester. Optional starvation stall: REGFILE_ARB_STALL_EN.
module regfile_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_en,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  dbg_req_valid,
    output logic                  dbg_req_ready,
    input  logic                  dbg_req_write,
    input  logic [ADDR_WIDTH-1:0] dbg_req_addr,
    input  logic [DATA_WIDTH-1:0] dbg_req_wdata,
    output logic                  dbg_rsp_valid,
    input  logic                  dbg_rsp_ready,
    output logic [DATA_WIDTH-1:0] dbg_rsp_rdata,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic [ADDR_WIDTH-1:0] rf_raddr,
    input  logic [DATA_WIDTH-1:0] rf_rdata,
    output logic                  core_stall
);

    arb_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  cnt_clr, cnt_inc;
    logic                  wb_owns, dbg_owns;

`ifdef REGFILE_ARB_STALL_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_cnt;

    regfile_arb_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .cnt   (starve_cnt)
    );

    assign core_stall = rst_n && (state_q == WRITE) && (starve_cnt == CNT_W'(STARVE_LIMIT));
`else
    logic unused_starve;
    assign unused_starve = ^{cnt_clr, cnt_inc, (STARVE_LIMIT > 0)};
    assign core_stall    = 1'b0;
`endif

    // Writeback wins the port unless stalled; debug write only gets it otherwise.
    assign wb_owns  = wb_en && !core_stall;
    assign dbg_owns = rst_n && !wb_owns && (state_q == WRITE);

    assign rf_waddr = dbg_owns ? addr_q  : wb_addr;
    assign rf_wdata = dbg_owns ? wdata_q : wb_data;
    assign rf_wen   = (wb_owns || dbg_owns) && (rf_waddr != '0);
    assign rf_raddr = addr_q;

    assign dbg_req_ready = rst_n && (state_q == IDLE);
    assign dbg_rsp_valid = rst_n && (state_q == RESP);
    assign dbg_rsp_rdata = rst_n ? rdata_q : '0;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (dbg_req_valid) begin
                    addr_d  = dbg_req_addr;
                    wdata_d = dbg_req_wdata;
                    state_d = dbg_req_write ? WRITE : READ;
                end
            end
            WRITE: begin
                if (dbg_owns) begin
                    rdata_d = DATA_WIDTH'(WRITE_RSP_DATA);
                    state_d = RESP;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            READ: begin
                // Forward a same-cycle writeback so the debugger sees the newest value.
                if (addr_q == '0) begin
                    rdata_d = '0;
                end else if (wb_owns && (wb_addr == addr_q)) begin
                    rdata_d = wb_data;
                end else begin
                    rdata_d = rf_rdata;
                end
                state_d = RESP;
            end
            RESP: begin
                if (dbg_rsp_ready) begin
                    cnt_clr = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Self-checking bench for regfile_arbiter: directed scenarios followed by
// randomized debug traffic against a register-content reference model.
module tb_regfile_arbiter;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int LIM = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          dbg_req_valid;
    logic          dbg_req_ready;
    logic          dbg_req_write;
    logic [AW-1:0] dbg_req_addr;
    logic [DW-1:0] dbg_req_wdata;
    logic          dbg_rsp_valid;
    logic          dbg_rsp_ready;
    logic [DW-1:0] dbg_rsp_rdata;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [AW-1:0] rf_raddr;
    logic [DW-1:0] rf_rdata;
    logic          core_stall;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] rf_mem [32];
    logic [DW-1:0] golden [32];
    logic          wb_hold;

    always #5 clk = ~clk;

    regfile_arbiter #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .STARVE_LIMIT (LIM)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wb_en         (wb_en),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .dbg_req_valid (dbg_req_valid),
        .dbg_req_ready (dbg_req_ready),
        .dbg_req_write (dbg_req_write),
        .dbg_req_addr  (dbg_req_addr),
        .dbg_req_wdata (dbg_req_wdata),
        .dbg_rsp_valid (dbg_rsp_valid),
        .dbg_rsp_ready (dbg_rsp_ready),
        .dbg_rsp_rdata (dbg_rsp_rdata),
        .rf_wen        (rf_wen),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .rf_raddr      (rf_raddr),
        .rf_rdata      (rf_rdata),
        .core_stall    (core_stall)
    );

    // Register file behind the arbiter: combinational read, clocked write.
    assign rf_rdata = rf_mem[rf_raddr];
    always @(posedge clk) begin
        if (rf_wen) rf_mem[rf_waddr] <= rf_wdata;
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rsp_done();
        dbg_rsp_ready = 1'b1;
        tick();
        dbg_rsp_ready = 1'b0;
        #1;
    endtask

    // One cycle of random writeback traffic to x16..x31; a stalled write is retried.
    task automatic bg_cycle();
        tick();
        if (!wb_hold) begin
            wb_en   = 1'($urandom_range(0, 1));
            wb_addr = AW'($urandom_range(16, 31));
            wb_data = $urandom;
        end
        #1;
        wb_hold = wb_en && core_stall;
        if (wb_en && !core_stall) golden[wb_addr] = wb_data;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            rf_mem[i] = 32'hA5A5_0000 | DW'(i);
            golden[i] = 32'hA5A5_0000 | DW'(i);
        end
        rst_n = 1'b0; wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h33;
        dbg_req_valid = 1'b0; dbg_req_write = 1'b0; dbg_req_addr = '0; dbg_req_wdata = '0;
        dbg_rsp_ready = 1'b0; wb_hold = 1'b0;

        // Reset: debug side quiet, writeback passes through.
        tick();
        golden[3] = 32'h33;
        check("rst_req_ready", 32'(dbg_req_ready), 32'd0);
        check("rst_rsp_valid", 32'(dbg_rsp_valid), 32'd0);
        check("rst_rsp_rdata", dbg_rsp_rdata, 32'd0);
        check("rst_core_stall", 32'(core_stall), 32'd0);
        check("rst_rf_wen", 32'(rf_wen), 32'd1);
        check("rst_rf_waddr", 32'(rf_waddr), 32'd3);
        wb_addr = 5'd0; #1;
        check("rst_rf_wen_x0", 32'(rf_wen), 32'd0);
        tick();
        rst_n = 1'b1; wb_en = 1'b0; #1;
        check("idle_ready", 32'(dbg_req_ready), 32'd1);

        // Uncontended debug write x5.
        dbg_req_valid = 1'b1; dbg_req_write = 1'b1; dbg_req_addr = 5'd5; dbg_req_wdata = 32'hDEADBEEF;
        tick();
        dbg_req_valid = 1'b0; #1;
        check("wr_rf_wen", 32'(rf_wen), 32'd1);
        check("wr_rf_waddr", 32'(rf_waddr), 32'd5);
        check("wr_rf_wdata", rf_wdata, 32'hDEADBEEF);
        check("wr_rsp_early", 32'(dbg_rsp_valid), 32'd0);
        check("wr_ready_busy", 32'(dbg_req_ready), 32'd0);
        tick();
        golden[5] = 32'hDEADBEEF;
        check("wr_rsp_valid", 32'(dbg_rsp_valid), 32'd1);
        check("wr_rsp_rdata", dbg_rsp_rdata, 32'd0);
        check("wr_mem5", rf_mem[5], 32'hDEADBEEF);
        rsp_done();
        check("wr_back_idle", 32'(dbg_req_ready), 32'd1);

        // Debug read x5 racing a same-cycle writeback to x5, then a held response.
        dbg_req_valid = 1'b1; dbg_req_write = 1'b0; dbg_req_addr = 5'd5;
        tick();
        dbg_req_valid = 1'b0; wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h12345678; #1;
        check("rd_raddr", 32'(rf_raddr), 32'd5);
        check("rd_wb_wen", 32'(rf_wen), 32'd1);
        golden[5] = 32'h12345678;
        tick();
        wb_en = 1'b0; #1;
        check("rd_rsp_valid", 32'(dbg_rsp_valid), 32'd1);
        check("rd_fwd_rdata", dbg_rsp_rdata, 32'h12345678);
        dbg_req_valid = 1'b1; dbg_req_write = 1'b1; dbg_req_addr = 5'd1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_rsp_valid", 32'(dbg_rsp_valid), 32'd1);
            check("hold_rdata", dbg_rsp_rdata, 32'h12345678);
            check("hold_req_ready", 32'(dbg_req_ready), 32'd0);
        end
        dbg_req_valid = 1'b0;
        rsp_done();
        check("hold_released", 32'(dbg_rsp_valid), 32'd0);
        check("hold_idle", 32'(dbg_req_ready), 32'd1);

        // x0 is hard-wired: writes suppressed, reads return 0.
        dbg_req_valid = 1'b1; dbg_req_write = 1'b1; dbg_req_addr = 5'd0; dbg_req_wdata = 32'hFFFFFFFF;
        tick();
        dbg_req_valid = 1'b0; #1;
        check("x0_wr_wen", 32'(rf_wen), 32'd0);
        tick();
        check("x0_wr_ack", 32'(dbg_rsp_valid), 32'd1);
        check("x0_wr_rdata", dbg_rsp_rdata, 32'd0);
        rsp_done();
        dbg_req_valid = 1'b1; dbg_req_write = 1'b0; dbg_req_addr = 5'd0;
        tick();
        dbg_req_valid = 1'b0;
        tick();
        check("x0_rd_valid", 32'(dbg_rsp_valid), 32'd1);
        check("x0_rd_rdata", dbg_rsp_rdata, 32'd0);
        rsp_done();

        // Debug write x7 under continuous writeback to x20.
        dbg_req_valid = 1'b1; dbg_req_write = 1'b1; dbg_req_addr = 5'd7; dbg_req_wdata = 32'hCAFEF00D;
        tick();
        dbg_req_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            wb_en = 1'b1; wb_addr = 5'd20; wb_data = 32'h1000 + DW'(i); #1;
`ifdef REGFILE_ARB_STALL_EN
            check("starve_stall", 32'(core_stall), 32'(i == LIM + 1));
            if (i == LIM + 1) begin
                check("starve_dbg_waddr", 32'(rf_waddr), 32'd7);
                check("starve_dbg_wdata", rf_wdata, 32'hCAFEF00D);
                check("starve_dbg_wen", 32'(rf_wen), 32'd1);
            end else begin
                golden[20] = wb_data;
            end
`else
            check("starve_stall", 32'(core_stall), 32'd0);
            check("starve_wb_waddr", 32'(rf_waddr), 32'd20);
            golden[20] = wb_data;
`endif
            tick();
        end
        wb_en = 1'b0; #1;
`ifndef REGFILE_ARB_STALL_EN
        check("starve_late_wen", 32'(rf_wen), 32'd1);
        check("starve_late_waddr", 32'(rf_waddr), 32'd7);
        tick();
`endif
        golden[7] = 32'hCAFEF00D;
        check("starve_rsp_valid", 32'(dbg_rsp_valid), 32'd1);
        check("starve_rsp_rdata", dbg_rsp_rdata, 32'd0);
        rsp_done();
        check("starve_mem7", rf_mem[7], 32'hCAFEF00D);
        check("starve_mem20", rf_mem[20], 32'h1014);

        // Reset while a debug write is pending: dropped without a write.
        dbg_req_valid = 1'b1; dbg_req_write = 1'b1; dbg_req_addr = 5'd9; dbg_req_wdata = 32'h99;
        tick();
        dbg_req_valid = 1'b0; rst_n = 1'b0; #1;
        check("mrst_wen", 32'(rf_wen), 32'd0);
        check("mrst_rsp", 32'(dbg_rsp_valid), 32'd0);
        tick();
        rst_n = 1'b1; #1;
        check("mrst_idle", 32'(dbg_req_ready), 32'd1);
        tick();
        tick();
        check("mrst_no_rsp", 32'(dbg_rsp_valid), 32'd0);
        check("mrst_mem9", rf_mem[9], golden[9]);

        // Random debug transactions to x0..x15 with background writeback traffic.
        for (int t = 0; t < 40; t++) begin
            logic          wr;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            logic [DW-1:0] exp;
            int            waited;
            wr = 1'($urandom_range(0, 1));
            a  = AW'($urandom_range(0, 15));
            d  = $urandom;
            exp = (wr || a == '0) ? '0 : golden[a];
            dbg_req_valid = 1'b1; dbg_req_write = wr; dbg_req_addr = a; dbg_req_wdata = d; #1;
            check("rnd_ready", 32'(dbg_req_ready), 32'd1);
            bg_cycle();
            dbg_req_valid = 1'b0;
            waited = 0;
            while (!dbg_rsp_valid && waited < 40) begin
                bg_cycle();
                waited++;
            end
            check("rnd_rsp_timeout", 32'(waited < 40), 32'd1);
            check("rnd_rsp_rdata", dbg_rsp_rdata, exp);
            if (wr && a != '0) golden[a] = d;
            repeat ($urandom_range(0, 2)) bg_cycle();
            check("rnd_rsp_held", 32'(dbg_rsp_valid), 32'd1);
            dbg_rsp_ready = 1'b1;
            bg_cycle();
            dbg_rsp_ready = 1'b0;
            check("rnd_idle", 32'(dbg_req_ready), 32'd1);
        end
        wb_en = 1'b0; wb_hold = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 32; i++) begin
            check($sformatf("rf_final[%0d]", i), rf_mem[i], golden[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Shares the core register file's single write port and a dedicated read port between the core writeback path and a debug requester (DPI/difftest restore, debugger register pokes). Writeback always has priority; debug reads and writes are sequenced through a small FSM with a valid/ready request channel and a valid/ready response channel. An optional starvation guard stalls the core for one cycle so a blocked debug write can complete. Sits between the writeback stage, the debug bridge and the register file.

## Interface
- DATA_WIDTH, 32, register width
- ADDR_WIDTH, 5, register index width (2^ADDR_WIDTH registers)
- STARVE_LIMIT, 8, lost cycles before a debug write forces a core stall (≥1)

- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- wb_en  in  1  writeback write request
- wb_addr  in  ADDR_WIDTH  writeback index
- wb_data  in  DATA_WIDTH  writeback data
- dbg_req_valid  in  1  debug request valid
- dbg_req_ready  out  1  debug request accepted
- dbg_req_write  in  1  1 = write, 0 = read
- dbg_req_addr  in  ADDR_WIDTH  debug index
- dbg_req_wdata  in  DATA_WIDTH  debug write data
- dbg_rsp_valid  out  1  response valid
- dbg_rsp_ready  in  1  response consumed
- dbg_rsp_rdata  out  DATA_WIDTH  read data (0 for write acks)
- rf_wen  out  1  register file write enable
- rf_waddr  out  ADDR_WIDTH  register file write index
- rf_wdata  out  DATA_WIDTH  register file write data
- rf_raddr  out  ADDR_WIDTH  debug read index (combinational-read port)
- rf_rdata  in  DATA_WIDTH  debug read data
- core_stall  out  1  core must hold its writeback this cycle

## Operation
- States: IDLE, WRITE, READ, RESP. Reset → IDLE, starve_cnt=0, latched addr/data/rdata=0.
- IDLE: dbg_req_ready=1. On dbg_req_valid&&ready, latch addr/wdata; go WRITE or READ per dbg_req_write.
- Write port mux: if core_stall=0 and wb_en=1 → writeback owns port. Else if state==WRITE → debug owns port, go RESP. rf_wen forced 0 whenever selected address is 0.
- WRITE with wb_en=1 and no stall: stay, starve_cnt+1 (saturating).
- READ: rf_raddr=latched addr; captured data = 0 if addr==0; wb_data if wb_en&&wb_addr==addr&&!core_stall; else rf_rdata. Go RESP.
- RESP: dbg_rsp_valid=1, rdata held stable until dbg_rsp_ready; then IDLE, starve_cnt=0.
- Write responses carry dbg_rsp_rdata=0.
- rf_raddr = latched addr in all states.

## Timing
- Reset values: dbg_req_ready=0 while rst_n=0, dbg_rsp_valid=0, dbg_rsp_rdata=0, core_stall=0, rf_wen=wb_en&&wb_addr!=0 (writeback pass-through unaffected by reset).
- dbg_req_ready, dbg_rsp_valid, core_stall decode from registered state only; no combinational path from dbg_req_valid.
- Uncontended latency: accept at edge N, port use in cycle N+1, dbg_rsp_valid from N+2.
- Back-to-back: new request accepted earliest the cycle after the response handshake.
- Simultaneous wb_en and debug write in WRITE: writeback wins unless core_stall=1.
- Reset mid-operation: pending request and response dropped, no write issued.

## Configuration
- REGFILE_ARB_STALL_EN defined: core_stall = (state==WRITE && starve_cnt==STARVE_LIMIT); in that cycle debug owns port, writeback ignored (core retries).
- Undefined: core_stall tied 0, starve_cnt removed; debug write waits until a cycle with wb_en=0.

## Structure
- Package regfile_arb_pkg: state enum (IDLE/WRITE/READ/RESP), state width constant, response-data-for-write constant (0).
- One sub-module: regfile_arb_starve_cnt (saturating counter, clear/inc, width $clog2(STARVE_LIMIT+1)), instantiated only under REGFILE_ARB_STALL_EN.

## Test plan
- Debug write x5=0xDEADBEEF, wb_en=0 → rf_wen in cycle N+1 to addr 5, dbg_rsp_valid at N+2, rdata=0.
- Debug read x5 while wb_en writes x5=0x12345678 same cycle → dbg_rsp_rdata=0x12345678.
- Debug write x0=0xFFFFFFFF → rf_wen stays 0, ack returned; debug read x0 → 0.
- wb_en held 1 for 20 cycles, debug write pending, STARVE_LIMIT=8, macro on → core_stall=1 exactly once, 9 cycles after entering WRITE, debug write committed that cycle; macro off → write commits first cycle wb_en=0.
- dbg_rsp_ready held 0 for 5 cycles → rsp_valid/rdata stable, dbg_req_ready=0 throughout.
- rst_n=0 during WRITE → next cycle IDLE, no debug write, no response.
